dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 85 ++++++++
 tb/tb_dm_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port data-memory arbiter, one transaction in flight, round-robin or fixed priority
// Ports: clk, rst_n (async, active-low); per port p in {0,1}: reqp/wep/addrp/wdatap in,
//        gntp/donep/errp/rdatap out; memory side: mem_read/mem_write/address/data_write out, data_read in.
module dm_arbiter #(
  parameter int DEPTH = 1024,
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] address,
  output logic [31:0] data_write,
  input  logic [31:0] data_read
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [31:0] MAX_ADDR = 32'(DEPTH - 4);
  state_t state, state_n;
  logic port, we_l, err_l, last;
  logic take, win, w_we, illegal;
  logic [31:0] w_addr, w_wdata;
  always_comb begin
    take = state == IDLE && (req0 || req1);
    // on a tie the port not granted last wins; a lone requester wins outright
    win = (req0 && req1) ? (RR_EN ? ~last : 1'b0) : req1;
    w_we = win ? we1 : we0;
    w_addr = win ? addr1 : addr0;
    w_wdata = win ? wdata1 : wdata0;
    illegal = |w_addr[1:0] || w_addr > MAX_ADDR;
    state_n = state == IDLE ? (take ? (illegal ? RESP : ACCESS) : IDLE) :
              state == ACCESS ? RESP : IDLE;
    mem_read = state == ACCESS && !we_l;
    mem_write = state == ACCESS && we_l;
    done0 = state == RESP && !port;
    done1 = state == RESP && port;
    err0 = done0 && err_l;
    err1 = done1 && err_l;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      port <= 1'b0;
      we_l <= 1'b0;
      err_l <= 1'b0;
      last <= 1'b1;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      address <= '0;
      data_write <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      state <= state_n;
      gnt0 <= take && !win;
      gnt1 <= take && win;
      if (take) begin
        port <= win;
        we_l <= w_we;
        err_l <= illegal;
        last <= win;
        if (!illegal) address <= w_addr;
        if (!illegal && w_we) data_write <= w_wdata;
      end
      // memory presents load data by the ACCESS->RESP edge
      if (state == ACCESS && !we_l && !port) rdata0 <= data_read;
      if (state == ACCESS && !we_l && port) rdata1 <= data_read;
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: table vectors, corner sequences and randomized transactions vs a transaction-level model
module tb_dm_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic gnt0, gnt1, done0, done1, err0, err1, mem_read, mem_write;
  logic [31:0] rdata0, rdata1, address, data_write, data_read;
  logic f_gnt0, f_gnt1, f_done0, f_done1, f_err0, f_err1, f_mem_read, f_mem_write;
  logic [31:0] f_rdata0, f_rdata1, f_address, f_data_write;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.DEPTH(1024), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .data_write(data_write), .data_read(data_read));

  dm_arbiter #(.DEPTH(1024), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(f_gnt0), .gnt1(f_gnt1), .done0(f_done0), .done1(f_done1), .err0(f_err0), .err1(f_err1),
    .rdata0(f_rdata0), .rdata1(f_rdata1), .mem_read(f_mem_read), .mem_write(f_mem_write),
    .address(f_address), .data_write(f_data_write), .data_read(32'h0));

  // data memory: acts on the strobes at negedge
  always @(negedge clk) begin
    if (mem_write) mem[address[9:2]] <= data_write;
    if (mem_read) data_read <= mem[address[9:2]];
  end

  always @(negedge clk) if (rst_n) begin
    checks++;
    if ((gnt0 && gnt1) || (done0 && done1) || (mem_read && mem_write)) begin
      errors++;
      $display("FAIL exclusivity: gnt=%b done=%b rd/wr=%b%b required no two high", {gnt1, gnt0}, {done1, done0}, mem_read, mem_write);
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", n, act, exp);
    end
  endtask

  typedef struct {
    logic r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic [1:0] eg;
    int elat;
    logic eerr;
    logic [31:0] erd;
    logic emr, emw;
    logic [31:0] ema, emd;
  } tvec_t;

  task automatic run(input tvec_t v, output logic [1:0] g, output logic [1:0] dn, output logic e,
                     output logic [31:0] rd, output int lat, output logic mr, output logic mw,
                     output logic [31:0] ma, output logic [31:0] md);
    req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    @(posedge clk); #1;
    g = {gnt1, gnt0}; mr = mem_read; mw = mem_write; ma = address; md = data_write;
    req0 = 0; req1 = 0; lat = 1;
    while (!(done0 || done1) && lat < 4) begin
      @(posedge clk); #1;
      lat++;
    end
    dn = {done1, done0}; e = done1 ? err1 : err0; rd = done1 ? rdata1 : rdata0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] gen_addr();
    int k = $urandom_range(0, 3);
    if (k == 0) return ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
    if (k == 1) return $urandom_range(0, 1) ? 32'hFFFF_FFFC : 32'(1024 + ($urandom_range(0, 1000) << 2));
    return $urandom_range(0, 255) << 2;
  endfunction

  tvec_t tbl [9];
  int q_rr[$], q_fp[$];

  initial begin
    logic [1:0] g, dn;
    logic e, mr, mw;
    logic [31:0] rd, ma, md, keep;
    int lat;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[4] = 32'hDEAD_BEEF;
    mem[255] = 32'hCAFE_F00D;
    #2;
    chk("rst_flags", 32'({gnt0, gnt1, done0, done1, err0, err1, mem_read, mem_write}), 32'h0);
    chk("rst_address", address, 32'h0);
    chk("rst_data_write", data_write, 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    do_reset();

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 2'b01, 2, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h10, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h20, 32'h0, 32'h1234_5678, 2'b10, 2, 1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 32'h1234_5678};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 32'h0, 2'b01, 2, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 32'h20, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h13, 32'h0, 32'h0, 32'h0, 2'b01, 1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h3FD, 32'h0, 32'h0, 32'h0, 2'b01, 1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h3FC, 32'h0, 32'h0, 32'h0, 2'b01, 2, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h3FC, 32'h0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h3FC, 32'h0, 32'h0, 2'b10, 2, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h3FC, 32'h0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h3FC, 32'h10, 32'h0, 32'h0, 2'b01, 2, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h3FC, 32'h0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 2'b10, 1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 32'h0};
    for (int i = 0; i < 9; i++) begin
      run(tbl[i], g, dn, e, rd, lat, mr, mw, ma, md);
      chk($sformatf("v%0d_gnt", i), 32'(g), 32'(tbl[i].eg));
      chk($sformatf("v%0d_latency", i), lat, tbl[i].elat);
      chk($sformatf("v%0d_done", i), 32'(dn), 32'(tbl[i].eg));
      chk($sformatf("v%0d_err", i), 32'(e), 32'(tbl[i].eerr));
      chk($sformatf("v%0d_rdata", i), rd, tbl[i].erd);
      chk($sformatf("v%0d_strobes", i), 32'({mr, mw}), 32'({tbl[i].emr, tbl[i].emw}));
      if (tbl[i].emr || tbl[i].emw) chk($sformatf("v%0d_address", i), ma, tbl[i].ema);
      if (tbl[i].emw) chk($sformatf("v%0d_data_write", i), md, tbl[i].emd);
    end

    // both ports requesting continuously
    do_reset();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h10; addr1 = 32'h3FC;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (gnt0 || gnt1) q_rr.push_back(gnt1 ? 1 : 0);
      if (f_gnt0 || f_gnt1) q_fp.push_back(f_gnt1 ? 1 : 0);
    end
    req0 = 0; req1 = 0;
    repeat (3) @(posedge clk); #1;
    chk("rr_grant_count", q_rr.size(), 4);
    chk("fp_grant_count", q_fp.size(), 4);
    for (int i = 0; i < q_rr.size() && i < 4; i++) chk($sformatf("rr_order%0d", i), q_rr[i], i % 2);
    for (int i = 0; i < q_fp.size() && i < 4; i++) chk($sformatf("fp_order%0d", i), q_fp[i], 0);

    // reset in the middle of a store's ACCESS cycle
    keep = mem[16];
    req0 = 1; we0 = 1; addr0 = 32'h40; wdata0 = 32'h5555_AAAA;
    @(posedge clk); #1;
    chk("rst_mid_pre_write", 32'(mem_write), 1);
    req1 = 1; we1 = 0; addr1 = 32'h10;
    #2 rst_n = 0;
    #1;
    chk("rst_mid_strobe", 32'({mem_write, mem_read}), 0);
    chk("rst_mid_flags", 32'({gnt0, gnt1, done0, done1, err0, err1}), 0);
    chk("rst_mid_address", address, 32'h0);
    chk("rst_mid_data_write", data_write, 32'h0);
    chk("rst_mid_rdata", rdata0 | rdata1, 32'h0);
    @(posedge clk); #3 rst_n = 1;
    chk("rst_mid_no_write", mem[16], keep);
    @(posedge clk); #1;
    chk("rst_mid_tie_gnt", 32'({gnt1, gnt0}), 32'b01);
    chk("rst_mid_no_done", 32'({done1, done0}), 0);
    req0 = 0; req1 = 0;
    repeat (3) @(posedge clk); #1;

    // randomized transactions against a transaction-level model
    do_reset();
    begin
      logic pend [2];
      logic pw [2];
      logic [31:0] pa [2], pd [2], ref_rd [2];
      int last = 1, w;
      logic legal;
      pend[0] = 0; pend[1] = 0; ref_rd[0] = 0; ref_rd[1] = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
      for (int it = 0; it < 150; it++) begin
        for (int p = 0; p < 2; p++) if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p] = 1; pw[p] = 1'($urandom_range(0, 1)); pa[p] = gen_addr(); pd[p] = $urandom;
        end
        req0 = pend[0]; we0 = pw[0]; addr0 = pa[0]; wdata0 = pd[0];
        req1 = pend[1]; we1 = pw[1]; addr1 = pa[1]; wdata1 = pd[1];
        @(posedge clk); #1;
        if (!pend[0] && !pend[1]) begin
          chk("rnd_idle", 32'({gnt1, gnt0, done1, done0}), 0);
          continue;
        end
        w = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
        last = w;
        chk("rnd_gnt", 32'({gnt1, gnt0}), 32'(1 << w));
        pend[w] = 0;
        if (w == 1) req1 = 0; else req0 = 0;
        legal = pa[w][1:0] == 2'b00 && pa[w] <= 32'd1020;
        if (legal) begin
          chk("rnd_strobes", 32'({mem_read, mem_write}), 32'({!pw[w], pw[w]}));
          chk("rnd_address", address, pa[w]);
          if (pw[w]) chk("rnd_data_write", data_write, pd[w]);
          @(posedge clk); #1;
          if (pw[w]) ref_mem[pa[w][9:2]] = pd[w];
          else ref_rd[w] = ref_mem[pa[w][9:2]];
        end else
          chk("rnd_bad_strobes", 32'({mem_read, mem_write}), 0);
        chk("rnd_done", 32'({done1, done0}), 32'(1 << w));
        chk("rnd_err", 32'(w == 1 ? err1 : err0), 32'(!legal));
        chk("rnd_rdata", w == 1 ? rdata1 : rdata0, ref_rd[w]);
        @(posedge clk); #1;
        chk("rnd_done_pulse", 32'({done1, done0, gnt1, gnt0}), 0);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
